// File: rtl/clken_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clken_pkg
//  Description : Shared constants and the configuration request record used
//                by the fractional clock-enable generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package clken_pkg;

    localparam int MAX_CHANNELS = 8;
    localparam int CH_W         = 3;
    // Widest ratio field the pending register can carry; W must not exceed it.
    localparam int MAX_W        = 16;

    typedef struct packed {
        logic [CH_W-1:0]  ch;
        logic [MAX_W-1:0] mul;
        logic [MAX_W-1:0] div;
    } cfg_req_t;

endpackage
`default_nettype wire

// File: rtl/clken_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : clken_gen_if
//  Description : Run-time ratio configuration port (valid/ready plus error
//                pulse) of the clock-enable generator.
//  Revision    : 1.0 - initial release
// ============================================================================
interface clken_gen_if #(
    parameter int W = 6
);
    import clken_pkg::*;

    logic            cfg_valid;
    logic            cfg_ready;
    logic [CH_W-1:0] cfg_ch;
    logic [W-1:0]    cfg_mul;
    logic [W-1:0]    cfg_div;
    logic            cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_mul, cfg_div,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_mul, cfg_div,
        output cfg_ready, cfg_err
    );

endinterface
`default_nettype wire

// File: rtl/clken_chan.sv
`default_nettype none
// ============================================================================
//  Module      : clken_chan
//  Description : One M/D strobe channel: W-bit phase accumulator, compare and
//                subtract, registered strobe and glitch-free ratio apply at
//                the channel's wrap point.
//                Macro CLKEN_PHASE180_EN adds the half-period strobe ce180.
//  Revision    : 1.0 - initial release
// ============================================================================
module clken_chan #(
    parameter int           W      = 6,
    parameter logic [W-1:0] INIT_M = 6'd1,
    parameter logic [W-1:0] INIT_D = 6'd2
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         apply_req,
    input  logic [W-1:0] new_mul,
    input  logic [W-1:0] new_div,
    output logic         ce,
`ifdef CLKEN_PHASE180_EN
    output logic         ce180,
`endif
    output logic         apply
);

    logic [W-1:0] r_acc_q, w_acc_d;
    logic [W-1:0] r_mul_q, w_mul_d;
    logic [W-1:0] r_div_q, w_div_d;
    logic         r_ce_q,  w_ce_d;
    logic [W:0]   w_s;
    logic         w_hit;

    // Accumulate M, wrap by D; a stopped channel (M = 0) takes updates at once.
    always_comb begin
        w_s     = {1'b0, r_acc_q} + {1'b0, r_mul_q};
        w_hit   = (w_s >= {1'b0, r_div_q});
        apply   = apply_req && (w_hit || (r_mul_q == '0));
        w_ce_d  = w_hit;
        w_mul_d = r_mul_q;
        w_div_d = r_div_q;
        // s - D < M fits in W bits, so modulo-2^W arithmetic is exact here.
        if (w_hit) begin
            w_acc_d = r_acc_q + r_mul_q - r_div_q;
        end else begin
            w_acc_d = w_s[W-1:0];
        end
        if (apply) begin
            w_mul_d = new_mul;
            w_div_d = new_div;
            w_acc_d = '0;
        end
    end

    // Channel state registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_acc_q <= '0;
            r_mul_q <= INIT_M;
            r_div_q <= INIT_D;
            r_ce_q  <= 1'b0;
        end else begin
            r_acc_q <= w_acc_d;
            r_mul_q <= w_mul_d;
            r_div_q <= w_div_d;
            r_ce_q  <= w_ce_d;
        end
    end

    assign ce = r_ce_q;

`ifdef CLKEN_PHASE180_EN
    logic [W-1:0] w_half;
    logic         r_ce180_q, w_ce180_d;

    // Strobe when the accumulator crosses D/2 without wrapping.
    always_comb begin
        w_half    = r_div_q >> 1;
        w_ce180_d = (r_acc_q < w_half) && (w_s >= {1'b0, w_half}) &&
                    (w_s < {1'b0, r_div_q});
    end

    // Half-period strobe register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ce180_q <= 1'b0;
        end else begin
            r_ce180_q <= w_ce180_d;
        end
    end

    assign ce180 = r_ce180_q;
`endif

endmodule
`default_nettype wire

// File: rtl/clken_gen.sv
`default_nettype none
// ============================================================================
//  Module      : clken_gen
//  Description : Multi-channel fractional clock-enable generator. Holds the
//                request check, the single pending update register and the
//                lock counter; the per-channel datapath lives in clken_chan.
//                Macro CLKEN_PHASE180_EN adds the ce180 half-period strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module clken_gen
    import clken_pkg::*;
#(
    parameter int                    CHANNELS    = 2,
    parameter int                    W           = 6,
    parameter logic [CHANNELS*W-1:0] INIT_MUL    = {6'd5, 6'd25},
    parameter logic [CHANNELS*W-1:0] INIT_DIV    = {6'd6, 6'd48},
    parameter int                    LOCK_CYCLES = 16
) (
    input  logic                CLK,
    input  logic                RST,
    clken_gen_if.slave          cfg,
    output logic [CHANNELS-1:0] ce,
`ifdef CLKEN_PHASE180_EN
    output logic [CHANNELS-1:0] ce180,
`endif
    output logic                locked
);

    localparam int                c_lock_w    = $clog2(LOCK_CYCLES + 1);
    localparam logic [c_lock_w-1:0] c_lock_last = c_lock_w'(LOCK_CYCLES - 1);
    localparam logic [CH_W:0]     c_channels  = (CH_W + 1)'(CHANNELS);

    logic                r_pend_vld_q, w_pend_vld_d;
    cfg_req_t            r_pend_q,     w_pend_d;
    logic                r_err_q,      w_err_d;
    logic [c_lock_w-1:0] r_cnt_q,      w_cnt_d;
    logic                r_locked_q,   w_locked_d;
    logic                w_handshake;
    logic                w_bad;
    logic                w_apply_any;
    logic [CHANNELS-1:0] w_apply;

    // Request check, pending register update and lock counter.
    always_comb begin
        w_handshake  = cfg.cfg_valid && !r_pend_vld_q;
        w_bad        = ({1'b0, cfg.cfg_ch} >= c_channels) ||
                       (cfg.cfg_div == '0) || (cfg.cfg_mul > cfg.cfg_div);
        w_apply_any  = |w_apply;
        w_err_d      = w_handshake && w_bad;
        w_pend_vld_d = r_pend_vld_q;
        w_pend_d     = r_pend_q;
        w_cnt_d      = r_cnt_q;
        w_locked_d   = r_locked_q;

        // Ready stays low through the apply cycle, so no accept can collide.
        if (r_pend_vld_q) begin
            if (w_apply_any) begin
                w_pend_vld_d = 1'b0;
            end
        end else if (w_handshake && !w_bad) begin
            w_pend_vld_d = 1'b1;
            w_pend_d.ch  = cfg.cfg_ch;
            w_pend_d.mul = MAX_W'(cfg.cfg_mul);
            w_pend_d.div = MAX_W'(cfg.cfg_div);
        end

        if (w_apply_any) begin
            w_cnt_d    = '0;
            w_locked_d = 1'b0;
        end else if (r_cnt_q == c_lock_last) begin
            w_locked_d = 1'b1;
        end else begin
            w_cnt_d = r_cnt_q + 1'b1;
        end
    end

    // Control registers; reset also discards any pending update.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pend_vld_q <= 1'b0;
            r_pend_q     <= '0;
            r_err_q      <= 1'b0;
            r_cnt_q      <= '0;
            r_locked_q   <= 1'b0;
        end else begin
            r_pend_vld_q <= w_pend_vld_d;
            r_pend_q     <= w_pend_d;
            r_err_q      <= w_err_d;
            r_cnt_q      <= w_cnt_d;
            r_locked_q   <= w_locked_d;
        end
    end

    assign cfg.cfg_ready = ~r_pend_vld_q;
    assign cfg.cfg_err   = r_err_q;
    assign locked        = r_locked_q;

    // Upper bits of the pending ratio fields are always zero for W < MAX_W.
    if (W < MAX_W) begin : g_pend_hi
        logic w_pend_hi_unused;
        assign w_pend_hi_unused = |{r_pend_q.mul[MAX_W-1:W], r_pend_q.div[MAX_W-1:W]};
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        logic w_req;
        assign w_req = r_pend_vld_q && (r_pend_q.ch == CH_W'(k));

        clken_chan #(
            .W      (W),
            .INIT_M (INIT_MUL[k*W +: W]),
            .INIT_D (INIT_DIV[k*W +: W])
        ) u_chan (
            .CLK       (CLK),
            .RST       (RST),
            .apply_req (w_req),
            .new_mul   (r_pend_q.mul[W-1:0]),
            .new_div   (r_pend_q.div[W-1:0]),
            .ce        (ce[k]),
`ifdef CLKEN_PHASE180_EN
            .ce180     (ce180[k]),
`endif
            .apply     (w_apply[k])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_clken_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clken_gen
//  Description : Directed self-checking bench for clken_gen (2 channels,
//                ch0 25/48, ch1 5/6). Expected values are queued when the
//                stimulus is applied and popped when the output is sampled.
//                Macro CLKEN_PHASE180_EN enables the ce180 phase steps.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clken_gen;

    logic       CLK = 1'b0;
    logic       RST;
    logic [1:0] ce;
    logic       locked;
`ifdef CLKEN_PHASE180_EN
    logic [1:0] ce180;
`endif

    always #5 CLK = ~CLK;

    clken_gen_if #(.W(6)) cfg_if ();

    clken_gen #(
        .CHANNELS    (2),
        .W           (6),
        .INIT_MUL    ({6'd5, 6'd25}),
        .INIT_DIV    ({6'd6, 6'd48}),
        .LOCK_CYCLES (16)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .cfg    (cfg_if),
        .ce     (ce),
`ifdef CLKEN_PHASE180_EN
        .ce180  (ce180),
`endif
        .locked (locked)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    task automatic expect_v(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL scoreboard: observed=%0d with no expected value queued", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_errors++;
                $error("FAIL %s: observed=%0d expected=%0d", t, obs, e);
            end
        end
    endtask

    // Outputs are sampled and inputs changed on the falling edge.
    task automatic step();
        @(negedge CLK);
    endtask

    task automatic send(input logic [2:0] ch, input logic [5:0] m, input logic [5:0] d);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = ch;
        cfg_if.cfg_mul   = m;
        cfg_if.cfg_div   = d;
    endtask

    initial begin
        int          cnt0;
        int          cnt1;
        logic        ok;
        logic [2:0]  bad_ch  [3];
        logic [5:0]  bad_mul [3];
        logic [5:0]  bad_div [3];

        RST              = 1'b1;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch    = '0;
        cfg_if.cfg_mul   = '0;
        cfg_if.cfg_div   = '0;
        repeat (2) step();

        // Reset values.
        expect_v("rst_ce", 0);
        expect_v("rst_locked", 0);
        expect_v("rst_ready", 1);
        expect_v("rst_err", 0);
        check(32'(ce));
        check(32'(locked));
        check(32'(cfg_if.cfg_ready));
        check(32'(cfg_if.cfg_err));

        // Free run from reset release: first strobes, lock time, long-run rate.
        RST = 1'b0;
        expect_v("ce_edge1", 0);
        expect_v("ce_edge2", 3);
        expect_v("locked_edge15", 0);
        expect_v("locked_edge16", 1);
        expect_v("ce0_count_4800", 2500);
        expect_v("ce1_count_4800", 4000);
        cnt0 = 0;
        cnt1 = 0;
        for (int n = 1; n <= 4800; n++) begin
            step();
            cnt0 += int'(ce[0]);
            cnt1 += int'(ce[1]);
            if (n == 1 || n == 2) check(32'(ce));
            if (n == 15 || n == 16) check(32'(locked));
        end
        check(32'(cnt0));
        check(32'(cnt1));

        // ch1 5/6 -> 1/4; ch1 accumulator is 0 here, so it wraps on the second edge.
        expect_v("ready_after_accept", 0);
        expect_v("ready_after_apply", 1);
        expect_v("ce1_on_apply", 1);
        expect_v("locked_drop", 0);
        for (int i = 0; i < 8; i++) expect_v("ce1_div4_pattern", (i % 4 == 3) ? 1 : 0);
        expect_v("relock_edge15", 0);
        expect_v("relock_edge16", 1);
        send(3'd1, 6'd1, 6'd4);
        step();
        cfg_if.cfg_valid = 1'b0;
        check(32'(cfg_if.cfg_ready));
        step();
        check(32'(cfg_if.cfg_ready));
        check(32'(ce[1]));
        check(32'(locked));
        for (int i = 0; i < 8; i++) begin
            step();
            check(32'(ce[1]));
        end
        repeat (7) step();
        check(32'(locked));
        step();
        check(32'(locked));

        // Rejected requests: M > D, channel out of range, D = 0.
        bad_ch[0] = 3'd1; bad_mul[0] = 6'd7; bad_div[0] = 6'd5;
        bad_ch[1] = 3'd2; bad_mul[1] = 6'd1; bad_div[1] = 6'd4;
        bad_ch[2] = 3'd0; bad_mul[2] = 6'd0; bad_div[2] = 6'd0;
        for (int i = 0; i < 3; i++) begin
            expect_v("err_pulse", 1);
            expect_v("ready_on_reject", 1);
            expect_v("err_clear", 0);
            send(bad_ch[i], bad_mul[i], bad_div[i]);
            step();
            cfg_if.cfg_valid = 1'b0;
            check(32'(cfg_if.cfg_err));
            check(32'(cfg_if.cfg_ready));
            step();
            check(32'(cfg_if.cfg_err));
        end
        expect_v("ce0_rate_after_reject", 25);
        expect_v("ce1_rate_after_reject", 12);
        cnt0 = 0;
        cnt1 = 0;
        repeat (48) begin
            step();
            cnt0 += int'(ce[0]);
            cnt1 += int'(ce[1]);
        end
        check(32'(cnt0));
        check(32'(cnt1));

        // Stop ch0 (M = 0), then 3/3 which applies next cycle and runs continuously.
        expect_v("stop_ready_wait", 1);
        expect_v("stop_ce0_on_apply", 1);
        expect_v("stopped_ce0_count", 0);
        send(3'd0, 6'd0, 6'd48);
        step();
        cfg_if.cfg_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (cfg_if.cfg_ready) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check(32'(ok));
        check(32'(ce[0]));
        cnt0 = 0;
        repeat (20) begin
            step();
            cnt0 += int'(ce[0]);
        end
        check(32'(cnt0));

        expect_v("full_ready_after_accept", 0);
        expect_v("full_ready_next_cycle", 1);
        expect_v("full_ce0_on_apply", 0);
        expect_v("full_ce0_count", 20);
        send(3'd0, 6'd3, 6'd3);
        step();
        cfg_if.cfg_valid = 1'b0;
        check(32'(cfg_if.cfg_ready));
        step();
        check(32'(cfg_if.cfg_ready));
        check(32'(ce[0]));
        cnt0 = 0;
        repeat (20) begin
            step();
            cnt0 += int'(ce[0]);
        end
        check(32'(cnt0));

        // Reset while ch1 update (2/4) is pending: it must be discarded.
        expect_v("pend_ready", 0);
        expect_v("mid_rst_ce", 0);
        expect_v("mid_rst_locked", 0);
        expect_v("mid_rst_ready", 1);
        expect_v("mid_rst_err", 0);
        expect_v("rerun_ce_edge1", 0);
        expect_v("rerun_ce_edge2", 3);
        expect_v("rerun_ce1_count6", 5);
        expect_v("rerun_locked_edge15", 0);
        expect_v("rerun_locked_edge16", 1);
        send(3'd1, 6'd2, 6'd4);
        step();
        cfg_if.cfg_valid = 1'b0;
        check(32'(cfg_if.cfg_ready));
        RST = 1'b1;
        #1;
        check(32'(ce));
        check(32'(locked));
        check(32'(cfg_if.cfg_ready));
        check(32'(cfg_if.cfg_err));
        step();
        step();
        RST  = 1'b0;
        cnt1 = 0;
        for (int n = 1; n <= 16; n++) begin
            step();
            if (n <= 6) cnt1 += int'(ce[1]);
            if (n == 1 || n == 2) check(32'(ce));
            if (n == 6) check(32'(cnt1));
            if (n == 15 || n == 16) check(32'(locked));
        end

`ifdef CLKEN_PHASE180_EN
        // ch1 1/4: ce180 two cycles after each ce, strictly alternating.
        expect_v("p180_ready_wait", 1);
        for (int i = 0; i < 8; i++) begin
            expect_v("ce180_pattern", (i % 4 == 1) ? 1 : 0);
            expect_v("ce_pattern", (i % 4 == 3) ? 1 : 0);
        end
        send(3'd1, 6'd1, 6'd4);
        step();
        cfg_if.cfg_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (cfg_if.cfg_ready) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check(32'(ok));
        for (int i = 0; i < 8; i++) begin
            step();
            check(32'(ce180[1]));
            check(32'(ce[1]));
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clken_gen.md
# clken_gen

Parametrised, fully synchronous clock-enable generator for the single-clock fabric. It derives `CHANNELS` fractional-rate strobes from one master clock using per-channel multiply/divide ratios, in the style of DCM CLKFX M/D synthesis but without any extra clock nets. Ratios can be changed at run time through a valid/ready port, and each change takes effect glitch-free at the channel's next wrap. A `locked` flag indicates when the strobes are stable. It sits beside the clock generator and feeds the CPU, video and peripheral enables.

## Interface
Parameters:
- `CHANNELS`, 2: number of independent strobe channels (1–8).
- `W`, 6: ratio field width. M and D range 0..2^W−1.
- `INIT_MUL`, {6'd5, 6'd25}: packed reset M values. Channel 0 occupies the LSBs.
- `INIT_DIV`, {6'd6, 6'd48}: packed reset D values.
- `LOCK_CYCLES`, 16: number of cycles from reset release, or from a config apply, until `locked` asserts.

Ports:
- `CLK`, in, 1: master clock.
- `RST`, in, 1: reset. Asynchronous, active-high.
- `ce`, out, CHANNELS: one-cycle enable strobe per channel.
- `ce180`, out, CHANNELS: half-period strobe. Present only with `CLKEN_PHASE180_EN`.
- `locked`, out, 1: all channels stable.
- `cfg_valid`, in, 1: config request.
- `cfg_ready`, out, 1: no update pending.
- `cfg_ch`, in, 3: target channel.
- `cfg_mul`, in, W: new M.
- `cfg_div`, in, W: new D.
- `cfg_err`, out, 1: one-cycle pulse marking a rejected request.

## Operation
- Each channel has an accumulator `acc` of W bits.
- Every cycle, compute `s = acc + M` at W+1 bits.
  - If `s >= D`: `acc <= s − D` and `ce` pulses.
  - Otherwise: `acc <= s`.
- Average strobe rate is f·M/D. The configuration must satisfy M ≤ D and D ≥ 1.
- M = 0 means the channel is stopped: `ce` never pulses.
- A request is accepted when `cfg_valid && cfg_ready` in the same cycle. It is rejected, with `cfg_err` pulsing one cycle after the request, when any of these hold:
  - `cfg_ch >= CHANNELS`
  - `cfg_div == 0`
  - `cfg_mul > cfg_div`

  A rejected request is not latched and `cfg_ready` stays high.
- An accepted request is latched into a single pending register and `cfg_ready` drops.
- The pending values are applied on the first cycle in which the target channel's `ce` would pulse. If the channel is stopped (M = 0), they are applied on the next cycle. On apply:
  - M and D are updated.
  - `acc` is cleared to 0.
  - The `ce` pulse of that cycle is still issued.
  - `cfg_ready` rises on the following cycle.
  - The lock counter restarts.
- Lock counter:
  - Cleared on reset. Counts to `LOCK_CYCLES − 1`, then `locked` = 1 and the counter holds.
  - A config apply clears `locked` and restarts the count.

## Timing
- Reset values:
  - `ce` = 0, `ce180` = 0, `locked` = 0, `cfg_ready` = 1, `cfg_err` = 0.
  - All `acc` = 0. M and D take their `INIT_*` values. The pending register is empty.
- `ce` and `ce180` are registered. The first `ce` for channel k appears ceil(D/M) cycles after reset release.
- `locked` rises exactly `LOCK_CYCLES` cycles after reset release.
- `cfg_ready` falls in the cycle after acceptance. Worst-case apply latency is ceil(D/M) + 1 cycles.
- If an apply and a new request occur in the same cycle, the new request is not accepted, because `cfg_ready` is still low.
- `RST` asserted mid-update discards the pending request and returns all state to reset values immediately (asynchronously).
- When M = D, `ce` is asserted continuously.

## Configuration
- Macro `CLKEN_PHASE180_EN`.
- When defined, with H = D >> 1: `ce180` pulses in a cycle where `acc < H` and `s >= H` and `s < D`. For M ≤ H this produces strobes that strictly alternate with `ce`.
- When undefined, the `ce180` port and its logic are absent.

## Structure
- Shared package `clken_pkg`: `MAX_CHANNELS = 8`, the width of `cfg_ch` (`CH_W = 3`), and a `cfg_req_t` struct holding {ch, mul, div}.
- One sub-module, `clken_chan`: accumulator, compare/subtract, strobe generation and apply logic. It is instantiated `CHANNELS` times.
- The top level holds the request check, the pending register and the lock counter.

## Test plan
- Reset release with ch0 at M=25, D=48: across 4800 cycles, exactly 2500 `ce[0]` pulses occur, and `locked` rises at cycle 16.
- Request ch1 to M=1, D=4 while ch1 runs at M=5, D=6: `cfg_ready` low until ch1's next `ce`; afterwards `ce[1]` fires every 4th cycle, `locked` drops, then re-rises 16 cycles later.
- Request with `cfg_mul`=7, `cfg_div`=5: `cfg_err` pulses for one cycle, `cfg_ready` stays 1, and the strobe rate is unchanged.
- Set ch0 to M=0, then request M=3, D=3: the request is applied on the next cycle and `ce[0]` stays high continuously.
- Assert `RST` while a request is pending: all outputs return to reset values, and after release the pending request is not applied.
- With `CLKEN_PHASE180_EN` and M=1, D=4: `ce180` fires at phase 2 and `ce` at phase 0, strictly alternating.
